adc_acq_ctrl: RTL and testbench

Acquisition controller for the ADC input path. It generates the ADC sample clock and discards a programmable number of settling samples after a start request. It then accumulates a programmable number of signed samples and publishes the arithmetically shifted sum on a register-width output with a one-cycle done pulse. It sits between the sequencer's configuration/trigger registers and the ADC pins, and replaces free-running capture when averaged, triggered readings are required.

---
 rtl/adc_acq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_adc_acq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_ctrl.sv
// ADC acquisition controller: sample-clock divider, settling-sample skip,
// signed accumulation of N samples and shifted result publication.
module adc_acq_ctrl #(
    parameter int W_AIO = 16,
    parameter int W_REG = 32,
    parameter int W_DIV = 8,
    parameter int W_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W_DIV-1:0] cfg_div,
    input  logic [W_CNT-1:0] cfg_num,
    input  logic [W_CNT-1:0] cfg_skip,
    input  logic [4:0]       cfg_shift,
    input  logic             start,
    input  logic             abort,
    output logic             adc_smp,
    input  logic [W_AIO-1:0] adc_in,
    output logic             busy,
    output logic             done,
    output logic [W_REG-1:0] reg_aio
);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACQ
    } state_e;

    // Divider state
    logic [W_DIV-1:0] div_q, div_d;
    logic [W_DIV-1:0] lim_q, lim_d;
    logic             lim_vld_q, lim_vld_d;
    logic [W_DIV-1:0] div_max;
    logic [W_DIV-1:0] div_lim;
    logic             div_tc;
    logic             smp_q, smp_d;
    logic             smp_dly_q;
    logic             strb;

    // FSM / datapath state
    state_e           state_q, state_d;
    logic [W_CNT-1:0] skip_q, skip_d;
    logic [W_CNT-1:0] ncnt_q, ncnt_d;
    logic [W_CNT-1:0] nlat_q, nlat_d;
    logic [W_CNT-1:0] skiplat_q, skiplat_d;
    logic [4:0]       shift_q, shift_d;
    logic [W_REG-1:0] acc_q, acc_d;
    logic [W_REG-1:0] reg_q, reg_d;
    logic             done_q, done_d;

    logic [W_CNT-1:0]        skip_inc;
    logic [W_CNT-1:0]        ncnt_inc;
    logic [W_REG-1:0]        smp_ext;
    logic signed [W_REG-1:0] acc_sum;
    logic signed [W_REG-1:0] res;

    // Until the first terminal count after reset the live cfg_div sets the
    // half-period; afterwards the value captured at terminal count is used.
    assign div_max = (cfg_div == '0) ? W_DIV'(1) : cfg_div;
    assign div_lim = lim_vld_q ? lim_q : (div_max - W_DIV'(1));
    assign div_tc  = (div_q == div_lim);
    assign strb    = smp_q & ~smp_dly_q;

    // Divider next state: count, toggle the sample clock at terminal count
    always_comb begin
        div_d     = div_q + W_DIV'(1);
        smp_d     = smp_q;
        lim_d     = lim_q;
        lim_vld_d = lim_vld_q;
        if (div_tc) begin
            div_d     = '0;
            smp_d     = ~smp_q;
            lim_d     = div_max - W_DIV'(1);
            lim_vld_d = 1'b1;
        end
    end

    // Divider registers and sample-clock delay for rise detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            lim_q     <= '0;
            lim_vld_q <= 1'b0;
            smp_q     <= 1'b0;
            smp_dly_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            lim_q     <= lim_d;
            lim_vld_q <= lim_vld_d;
            smp_q     <= smp_d;
            smp_dly_q <= smp_q;
        end
    end

    assign skip_inc = skip_q + W_CNT'(1);
    assign ncnt_inc = ncnt_q + W_CNT'(1);
    assign smp_ext  = {{(W_REG-W_AIO){adc_in[W_AIO-1]}}, adc_in};
    assign acc_sum  = $signed(acc_q + smp_ext);
    assign res      = acc_sum >>> shift_q;

    // FSM next state: config latch on start, skip counting, accumulation
    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        ncnt_d    = ncnt_q;
        nlat_d    = nlat_q;
        skiplat_d = skiplat_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        reg_d     = reg_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    nlat_d    = (cfg_num == '0) ? W_CNT'(1) : cfg_num;
                    skiplat_d = cfg_skip;
                    shift_d   = cfg_shift;
                    acc_d     = '0;
                    skip_d    = '0;
                    ncnt_d    = '0;
                    state_d   = (cfg_skip != '0) ? SKIP : ACQ;
                end
            end
            SKIP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (strb) begin
                    skip_d = skip_inc;
                    if (skip_inc == skiplat_q) begin
                        state_d = ACQ;
                    end
                end
            end
            ACQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (strb) begin
                    acc_d  = acc_sum;
                    ncnt_d = ncnt_inc;
                    if (ncnt_inc == nlat_q) begin
                        reg_d   = res;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            skip_q    <= '0;
            ncnt_q    <= '0;
            nlat_q    <= '0;
            skiplat_q <= '0;
            shift_q   <= '0;
            acc_q     <= '0;
            reg_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            ncnt_q    <= ncnt_d;
            nlat_q    <= nlat_d;
            skiplat_q <= skiplat_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            reg_q     <= reg_d;
            done_q    <= done_d;
        end
    end

    assign adc_smp = smp_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign reg_aio = reg_q;

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed testbench for adc_acq_ctrl: averaging, skip, abort,
// ignored starts and mid-acquisition reset.
module tb_adc_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_div;
    logic [7:0]  cfg_num;
    logic [7:0]  cfg_skip;
    logic [4:0]  cfg_shift;
    logic        start;
    logic        abort;
    logic        adc_smp;
    logic [15:0] adc_in;
    logic        busy;
    logic        done;
    logic [31:0] reg_aio;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int dcnt   = 0;
    int t_last = 0;

    logic signed [15:0] smp [8];

    adc_acq_ctrl #(
        .W_AIO(16),
        .W_REG(32),
        .W_DIV(8),
        .W_CNT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_div  (cfg_div),
        .cfg_num  (cfg_num),
        .cfg_skip (cfg_skip),
        .cfg_shift(cfg_shift),
        .start    (start),
        .abort    (abort),
        .adc_smp  (adc_smp),
        .adc_in   (adc_in),
        .busy     (busy),
        .done     (done),
        .reg_aio  (reg_aio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done === 1'b1) dcnt <= dcnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for adc_smp to transition to lvl, seen at a negedge
    task automatic wait_edge(input logic lvl);
        logic p;
        bit   hit;
        p   = adc_smp;
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            if (adc_smp === lvl && p !== lvl) hit = 1'b1;
            p = adc_smp;
        end
        chk("smp_edge", 32'(hit), 32'd1);
    endtask

    // mode 0 normal, 1 start while busy, 2 abort mid-ACQ,
    // 3 abort on final strobe
    task automatic acq(input int mode, input int ns,
                       input logic [7:0] num, input logic [7:0] skip,
                       input logic [4:0] sh, input logic [31:0] exp);
        int d0;
        bit hit;
        d0 = dcnt;
        wait_edge(1'b0);
        adc_in    = smp[0];
        cfg_num   = num;
        cfg_skip  = skip;
        cfg_shift = sh;
        start     = 1'b1;
        t_last    = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
        for (int i = 1; i < ns; i++) begin
            wait_edge(1'b0);
            adc_in = smp[i];
            t_last = cyc;
            if (mode == 1 && i == 1) begin
                start     = 1'b1;
                cfg_num   = 8'd1;
                cfg_shift = 5'd1;
                @(negedge clk);
                start     = 1'b0;
                cfg_num   = num;
                cfg_shift = sh;
                chk("busy_hold", 32'(busy), 32'd1);
            end
            if (mode == 2 && i == 2) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_mid_busy", 32'(busy), 32'd0);
                break;
            end
            if (mode == 3 && i == ns - 1) begin
                wait_edge(1'b1);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_fin_busy", 32'(busy), 32'd0);
            end
        end
        if (mode >= 2) begin
            repeat (12) @(negedge clk);
            chk("no_done", 32'(dcnt - d0), 32'd0);
            chk("reg_keep", reg_aio, exp);
        end else begin
            hit = 1'b0;
            for (int n = 0; n < 40 && !hit; n++) begin
                @(negedge clk);
                if (done === 1'b1) hit = 1'b1;
            end
            chk("done_seen", 32'(hit), 32'd1);
            chk("done_lat", 32'(cyc - t_last), 32'(int'(cfg_div) + 1));
            chk("result", reg_aio, exp);
            chk("busy_off", 32'(busy), 32'd0);
            @(negedge clk);
            chk("done_1cyc", 32'(done), 32'd0);
            chk("done_cnt", 32'(dcnt - d0), 32'd1);
        end
    endtask

    initial begin
        int t0;
        int n;
        int d0;
        rst_n     = 1'b0;
        cfg_div   = 8'd2;
        cfg_num   = 8'd0;
        cfg_skip  = 8'd0;
        cfg_shift = 5'd0;
        start     = 1'b0;
        abort     = 1'b0;
        adc_in    = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_smp", 32'(adc_smp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_reg", reg_aio, 32'd0);
        rst_n = 1'b1;

        wait_edge(1'b1);
        t0 = cyc;
        wait_edge(1'b1);
        chk("smp_period4", 32'(cyc - t0), 32'd4);

        smp = '{100, 200, 300, 400, 0, 0, 0, 0};
        acq(0, 4, 8'd4, 8'd0, 5'd2, 32'd250);

        smp = '{-8, -8, -8, -8, 0, 0, 0, 0};
        acq(0, 4, 8'd4, 8'd0, 5'd4, 32'hFFFF_FFFE);

        smp[0] = 16'sh7FFF;
        acq(0, 1, 8'd0, 8'd0, 5'd0, 32'h0000_7FFF);

        smp = '{1, 2, 3, 4, 5, 0, 0, 0};
        acq(0, 5, 8'd2, 8'd3, 5'd0, 32'd9);

        smp = '{10, 20, 30, 40, 0, 0, 0, 0};
        acq(2, 4, 8'd4, 8'd0, 5'd0, 32'd9);
        acq(0, 4, 8'd4, 8'd0, 5'd0, 32'd100);

        smp = '{1, 1, 1, 1, 0, 0, 0, 0};
        acq(3, 4, 8'd4, 8'd0, 5'd0, 32'd100);

        d0 = dcnt;
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        cfg_num = 8'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("idle_abort_done", 32'(dcnt - d0), 32'd0);
        chk("idle_abort_reg", reg_aio, 32'd100);

        smp = '{5, 6, 7, 8, 0, 0, 0, 0};
        acq(1, 4, 8'd4, 8'd0, 5'd0, 32'd26);

        wait_edge(1'b0);
        adc_in   = 16'd1;
        cfg_skip = 8'd3;
        cfg_num  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_edge(1'b0);
        chk("skip_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_smp", 32'(adc_smp), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_reg", reg_aio, 32'd0);
        cfg_div = 8'd3;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (adc_smp !== 1'b1 && n < 20);
        chk("rst_first_rise", 32'(n), 32'd3);
        t0 = cyc;
        wait_edge(1'b1);
        chk("smp_period6", 32'(cyc - t0), 32'd6);
        cfg_div = 8'd2;
        repeat (20) @(negedge clk);

        smp = '{100, 200, 300, 400, 0, 0, 0, 0};
        acq(0, 4, 8'd4, 8'd0, 5'd2, 32'd250);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
